fetch_prefetch_unit: RTL and testbench

Instruction-fetch front end for the 5-stage RV32I pipeline. It sits directly upstream of the IF/ID pipeline register. It issues word reads to a variable-latency instruction memory over a request/grant/response handshake and buffers returned instructions with their PCs in a small FIFO. It presents the FIFO head to the decode stage and honours decode stall and execute-stage redirects (taken branch or jump).

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_prefetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch front end.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} pairs; clear wins over push/pop.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign head_data = mem[rd_ptr];

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// IF-stage prefetcher: one outstanding imem read, {pc, instr} buffered for decode.
// Define FETCH_BYPASS_EN to forward a returning word straight to decode when the buffer is empty.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            valid_f,
    output logic [XLEN-1:0] instr_f,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] pc_plus4_f
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    logic [XLEN-1:0]  fetch_pc_q;
    logic [XLEN-1:0]  req_pc_q;
    logic             grant;
    logic             push_req;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic             bypass_hit;
    logic             bypass_take;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    // Request side looks only at registered state so redirect never reaches imem combinationally.
    assign imem_req  = (state_q == IDLE) && (fifo_count < CNT_W'(DEPTH));
    assign imem_addr = word_align(fetch_pc_q);
    assign grant     = imem_req && imem_gnt;

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = (state_q == WAIT) && fifo_empty && imem_rvalid && !redirect;
`else
    assign bypass_hit = 1'b0;
`endif
    assign bypass_take = bypass_hit && !stall_f;

    always_comb begin
        state_d  = state_q;
        push_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = redirect ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d  = IDLE;
                    push_req = !redirect && !bypass_take;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= word_align(RESET_PC);
            req_pc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (redirect) begin
                fetch_pc_q <= word_align(redirect_pc);
            end else if (grant) begin
                fetch_pc_q <= fetch_pc_q + XLEN'(4);
            end
            if (grant) begin
                req_pc_q <= fetch_pc_q;
            end
        end
    end

    // Full can never coincide with a push (grant needs room); the guard just keeps the FIFO safe.
    assign fifo_push  = push_req && !fifo_full;
    assign fifo_pop   = !fifo_empty && !stall_f && !redirect;
    assign push_entry = '{pc: req_pc_q, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head_data (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        valid_f = 1'b0;
        instr_f = NOP_INSTR;
        pc_f    = '0;
        if (!fifo_empty) begin
            valid_f = 1'b1;
            instr_f = head_entry.instr;
            pc_f    = head_entry.pc;
        end else if (bypass_hit) begin
            valid_f = 1'b1;
            instr_f = imem_rdata;
            pc_f    = req_pc_q;
        end
    end

    assign pc_plus4_f = pc_f + XLEN'(4);

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: directed vector table, corner sequences and a
// randomized run against a queue-based reference model with a variable-latency memory.
module tb_fetch_prefetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stall_f;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid_f;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;

    fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_f     (stall_f),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .valid_f     (valid_f),
        .instr_f     (instr_f),
        .pc_f        (pc_f),
        .pc_plus4_f  (pc_plus4_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef struct {
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic        bp_valid;
        logic [31:0] pc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: delivered-instruction queue, memory with one outstanding read, stream PCs.
    entry_t      q[$];
    logic        mem_busy;
    logic        mem_live;
    logic [31:0] mem_addr;
    int          mem_delay;
    int          delay_min;
    int          delay_max;
    int          gnt_pct;
    logic        const_data;
    logic [31:0] stream_pc;
    logic [31:0] req_exp;
    logic        exp_valid;
    logic        bypass_exp;
    int          delivered;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (const_data) return 32'h00A0_0093;
        return {addr[15:0], addr[31:16]} ^ 32'h0F0F_0033;
    endfunction

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0b expected %0b", name, $time, got, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic r, input logic [31:0] rpc);
        stall_f     = s;
        redirect    = r;
        redirect_pc = rpc;
        imem_rvalid = mem_busy && (mem_delay == 0);
        imem_rdata  = imem_rvalid ? mem_word(mem_addr) : 32'hDEAD_BEEF;
        imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
    endtask

    task automatic check_output();
        logic [31:0] epc;
        logic [31:0] einstr;
        logic        ereq;
        bypass_exp = BYPASS && mem_busy && mem_live && imem_rvalid && (q.size() == 0) && !redirect;
        exp_valid  = (q.size() != 0) || bypass_exp;
        epc        = 32'h0;
        einstr     = NOP_INSTR;
        if (q.size() != 0) begin
            epc    = q[0].pc;
            einstr = q[0].instr;
        end else if (bypass_exp) begin
            epc    = mem_addr;
            einstr = imem_rdata;
        end
        ereq = !mem_busy && (q.size() < DEPTH);
        check1("valid_f", valid_f, exp_valid);
        check32("pc_f", pc_f, epc);
        check32("instr_f", instr_f, einstr);
        check32("pc_plus4_f", pc_plus4_f, epc + 32'd4);
        check1("imem_req", imem_req, ereq);
        if (ereq) check32("imem_addr", imem_addr, req_exp);
        check1("push_when_full", dut.push_req && dut.fifo_full, 1'b0);
    endtask

    task automatic end_cycle();
        logic        consumed;
        logic        grant;
        logic        pushing;
        logic [31:0] tgt;
        entry_t      e;
        tgt      = {redirect_pc[31:2], 2'b00};
        consumed = exp_valid && !stall_f && !redirect;
        grant    = imem_req && imem_gnt;
        pushing  = mem_busy && mem_live && imem_rvalid && !redirect && !(bypass_exp && !stall_f);
        if (consumed) begin
            check32("stream_pc", pc_f, stream_pc);
            check32("stream_instr", instr_f, mem_word(stream_pc));
            stream_pc = stream_pc + 32'd4;
            delivered++;
        end
        if (redirect) begin
            q.delete();
            stream_pc = tgt;
        end else begin
            if (consumed && q.size() > 0) void'(q.pop_front());
            if (pushing) begin
                e.pc    = mem_addr;
                e.instr = imem_rdata;
                q.push_back(e);
            end
        end
        if (redirect) mem_live = 1'b0;
        if (imem_rvalid) mem_busy = 1'b0;
        else if (mem_busy && mem_delay > 0) mem_delay--;
        if (grant) begin
            mem_busy  = 1'b1;
            mem_live  = !redirect;
            mem_addr  = imem_addr;
            mem_delay = $urandom_range(delay_min, delay_max);
        end
        if (redirect) req_exp = tgt;
        else if (grant) req_exp = req_exp + 32'd4;
        @(negedge clk);
    endtask

    task automatic run_cycle(input logic s, input logic r, input logic [31:0] rpc);
        apply_stimulus(s, r, rpc);
        #1;
        check_output();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        stall_f     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        q.delete();
        mem_busy  = 1'b0;
        mem_live  = 1'b0;
        mem_delay = 0;
        stream_pc = RESET_PC;
        req_exp   = RESET_PC;
        #1;
        check1("rst_valid_f", valid_f, 1'b0);
        check32("rst_instr_f", instr_f, NOP_INSTR);
        check32("rst_pc_f", pc_f, 32'h0);
        check32("rst_pc_plus4_f", pc_plus4_f, 32'h4);
        check32("rst_imem_addr", imem_addr, RESET_PC);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[16];
        logic found;
        logic [31:0] tgt;

        tbl[0]  = '{1'b1, 1'b1, 32'd0,  1'b0, 1'b0, 32'd0};
        tbl[1]  = '{1'b1, 1'b0, 32'd0,  1'b0, 1'b1, 32'd0};
        tbl[2]  = '{1'b1, 1'b1, 32'd4,  1'b1, 1'b1, 32'd0};
        tbl[3]  = '{1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd0};
        tbl[4]  = '{1'b1, 1'b1, 32'd8,  1'b1, 1'b1, 32'd0};
        tbl[5]  = '{1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd0};
        tbl[6]  = '{1'b1, 1'b1, 32'd12, 1'b1, 1'b1, 32'd0};
        tbl[7]  = '{1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd0};
        tbl[8]  = '{1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd0};
        tbl[9]  = '{1'b1, 1'b0, 32'd0,  1'b1, 1'b1, 32'd0};
        tbl[10] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 32'd0};
        tbl[11] = '{1'b0, 1'b1, 32'd16, 1'b1, 1'b1, 32'd4};
        tbl[12] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 32'd8};
        tbl[13] = '{1'b0, 1'b1, 32'd20, 1'b1, 1'b1, 32'd12};
        tbl[14] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 32'd16};
        tbl[15] = '{1'b0, 1'b1, 32'd24, 1'b1, 1'b1, 32'd20};

        rst        = 1'b0;
        const_data = 1'b1;
        gnt_pct    = 100;
        delay_min  = 0;
        delay_max  = 0;
        delivered  = 0;
        #2;
        do_reset();

        $display("[TB] vector table: stall from reset, fill, release");
        for (int i = 0; i < 16; i++) begin
            logic ev;
            run_cycle(tbl[i].stall, 1'b0, 32'h0);
            ev = BYPASS ? tbl[i].bp_valid : tbl[i].valid;
            check1($sformatf("tbl_req[%0d]", i), imem_req, tbl[i].req);
            if (tbl[i].req) check32($sformatf("tbl_addr[%0d]", i), imem_addr, tbl[i].addr);
            check1($sformatf("tbl_valid[%0d]", i), valid_f, ev);
            check32($sformatf("tbl_pc[%0d]", i), pc_f, tbl[i].pc);
            check32($sformatf("tbl_instr[%0d]", i), instr_f, ev ? 32'h00A0_0093 : NOP_INSTR);
            end_cycle();
        end

        $display("[TB] sequence: first-instruction latency");
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 1'b0, 32'h0);
            check1($sformatf("lat_valid[%0d]", i), valid_f, (i == 2) || (BYPASS && i == 1));
            end_cycle();
        end

        $display("[TB] sequence: redirect while waiting");
        do_reset();
        const_data = 1'b0;
        delay_min  = 2;
        delay_max  = 2;
        run_cycle(1'b0, 1'b0, 32'h0);
        check32("t3_first_addr", imem_addr, RESET_PC);
        end_cycle();
        run_cycle(1'b0, 1'b1, 32'h100);
        end_cycle();
        run_cycle(1'b0, 1'b0, 32'h0);
        check1("t3_drop_valid", valid_f, 1'b0);
        check1("t3_drop_req", imem_req, 1'b0);
        end_cycle();
        run_cycle(1'b0, 1'b0, 32'h0);
        check1("t3_rvalid_req", imem_req, 1'b0);
        end_cycle();
        run_cycle(1'b0, 1'b0, 32'h0);
        check1("t3_new_req", imem_req, 1'b1);
        check32("t3_new_addr", imem_addr, 32'h100);
        end_cycle();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            run_cycle(1'b0, 1'b0, 32'h0);
            if (valid_f) begin
                found = 1'b1;
                check32("t3_first_pc", pc_f, 32'h100);
            end
            end_cycle();
        end
        check1("t3_valid_seen", found, 1'b1);

        $display("[TB] sequence: redirect with rvalid and pop");
        do_reset();
        delay_min = 0;
        delay_max = 0;
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b1, 1'b0, 32'h0);
            end_cycle();
        end
        run_cycle(1'b0, 1'b0, 32'h0);
        end_cycle();
        run_cycle(1'b0, 1'b1, 32'h200);
        check1("t4_valid_before", valid_f, 1'b1);
        check32("t4_pc_before", pc_f, 32'h4);
        end_cycle();
        run_cycle(1'b0, 1'b0, 32'h0);
        check1("t4_valid_after", valid_f, 1'b0);
        check1("t4_req_after", imem_req, 1'b1);
        check32("t4_addr_after", imem_addr, 32'h200);
        end_cycle();

        $display("[TB] sequence: reset mid-transaction");
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_cycle(1'b1, 1'b0, 32'h0);
            end_cycle();
        end
        run_cycle(1'b1, 1'b0, 32'h0);
        check32("t5_pc_before", pc_f, 32'h0);
        do_reset();
        run_cycle(1'b0, 1'b0, 32'h0);
        check1("t5_req_after", imem_req, 1'b1);
        check32("t5_addr_after", imem_addr, RESET_PC);
        check1("t5_valid_after", valid_f, 1'b0);
        end_cycle();

        $display("[TB] randomized run against reference model");
        do_reset();
        gnt_pct   = 60;
        delay_min = 0;
        delay_max = 5;
        delivered = 0;
        for (int i = 0; i < 3000; i++) begin
            logic s;
            logic r;
            if (i == 1500) do_reset();
            s = ($urandom_range(0, 99) < 30);
            r = ($urandom_range(0, 99) < 4);
            case ($urandom_range(0, 3))
                0:       tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                1:       tgt = $urandom & 32'h0000_0FFF;
                default: tgt = $urandom;
            endcase
            run_cycle(s, r, tgt);
            end_cycle();
        end
        check1("rand_progress", delivered > 100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
